perf_counter_reader: RTL

CSR-side read/control agent for the 64-bit performance counters (`counter_64` instances for cycle and instret). It serves 32-bit CSR requests from the pipeline's CSR unit over a four-phase req/ack handshake. It returns either half of each 64-bit counter, with an optional hi-half snapshot so a lo-then-hi read pair is consistent. It also drives the counters' `keep` and `clear` controls from an inhibit register and clear writes.

---
 rtl/perf_counter_reader.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/perf_counter_reader.sv
// -----------------------------------------------------------------------------
// perf_counter_reader
//
// CSR-side read/control agent for the 64-bit cycle and instret performance
// counters. Serves 32-bit CSR requests over a four-phase req/ack handshake,
// returns either half of each counter, and drives the counters' keep
// (inhibit) and clear controls.
//
// Optional feature macro: COUNTER_SNAPSHOT_EN
//   When defined, a lo-half read latches the matching hi half into a shadow
//   register so that a following hi-half read returns a consistent value.
//   When undefined, hi-half reads always return the live value.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   cycle_count    live 64-bit cycle counter value
//   instret_count  live 64-bit instret counter value
//   csr_req        request, held with we/addr/wdata until csr_ack is seen
//   csr_we         1 = write, 0 = read
//   csr_addr       CSR address (ADDR_W bits)
//   csr_wdata      write data
//   csr_ack        one-cycle response strobe
//   csr_err        illegal access, valid with csr_ack
//   csr_rdata      read data, valid with csr_ack (0 on writes and errors)
//   cycle_keep     inhibit control to the cycle counter
//   instret_keep   inhibit control to the instret counter
//   cycle_clear    one-cycle clear pulse to the cycle counter
//   instret_clear  one-cycle clear pulse to the instret counter
// -----------------------------------------------------------------------------
module perf_counter_reader #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [63:0]       cycle_count,
   input  logic [63:0]       instret_count,
   input  logic              csr_req,
   input  logic              csr_we,
   input  logic [ADDR_W-1:0] csr_addr,
   input  logic [31:0]       csr_wdata,
   output logic              csr_ack,
   output logic              csr_err,
   output logic [31:0]       csr_rdata,
   output logic              cycle_keep,
   output logic              instret_keep,
   output logic              cycle_clear,
   output logic              instret_clear
);

   localparam logic [ADDR_W-1:0] A_CYC_LO  = ADDR_W'(12'hC00);
   localparam logic [ADDR_W-1:0] A_CYC_HI  = ADDR_W'(12'hC80);
   localparam logic [ADDR_W-1:0] A_INS_LO  = ADDR_W'(12'hC02);
   localparam logic [ADDR_W-1:0] A_INS_HI  = ADDR_W'(12'hC82);
   localparam logic [ADDR_W-1:0] A_INHIBIT = ADDR_W'(12'h320);
   localparam logic [ADDR_W-1:0] A_CYC_CLR = ADDR_W'(12'hB00);
   localparam logic [ADDR_W-1:0] A_INS_CLR = ADDR_W'(12'hB02);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RESP  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]  state, state_next;
   logic        accept;

   logic        dec_err;
   logic [31:0] dec_rdata;
   logic        dec_wr_inhibit;
   logic        dec_clr_cyc;
   logic        dec_clr_ins;

   // Only bits 0 and 2 of the write data carry meaning (inhibit bits).
   logic        unused_wdata;
   assign unused_wdata = ^{csr_wdata[31:3], csr_wdata[1]};

`ifdef COUNTER_SNAPSHOT_EN
   logic        cyc_snap_valid, ins_snap_valid;
   logic [31:0] cyc_shadow, ins_shadow;
   logic        dec_cyc_load, dec_cyc_use;
   logic        dec_ins_load, dec_ins_use;
`endif

   // A request is taken only from IDLE; everything the access does happens
   // at this single edge, including counter sampling.
   assign accept = (state == ST_IDLE) && csr_req;

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (csr_req)  state_next = ST_RESP;
         ST_RESP:  state_next = csr_req ? ST_DRAIN : ST_IDLE;
         ST_DRAIN: if (!csr_req) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Address decode. Writes to read-only counters and unmapped addresses
   // report an error and leave every control untouched.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // through the case can leave a value held, which would infer a latch.
      dec_err        = 1'b0;
      dec_rdata      = '0;
      dec_wr_inhibit = 1'b0;
      dec_clr_cyc    = 1'b0;
      dec_clr_ins    = 1'b0;
`ifdef COUNTER_SNAPSHOT_EN
      dec_cyc_load   = 1'b0;
      dec_cyc_use    = 1'b0;
      dec_ins_load   = 1'b0;
      dec_ins_use    = 1'b0;
`endif
      case (csr_addr)
         A_CYC_LO: begin
            if (csr_we) dec_err = 1'b1;
            else begin
               dec_rdata = cycle_count[31:0];
`ifdef COUNTER_SNAPSHOT_EN
               dec_cyc_load = 1'b1;
`endif
            end
         end
         A_CYC_HI: begin
            if (csr_we) dec_err = 1'b1;
`ifdef COUNTER_SNAPSHOT_EN
            else if (cyc_snap_valid) begin
               dec_rdata   = cyc_shadow;
               dec_cyc_use = 1'b1;
            end
`endif
            else dec_rdata = cycle_count[63:32];
         end
         A_INS_LO: begin
            if (csr_we) dec_err = 1'b1;
            else begin
               dec_rdata = instret_count[31:0];
`ifdef COUNTER_SNAPSHOT_EN
               dec_ins_load = 1'b1;
`endif
            end
         end
         A_INS_HI: begin
            if (csr_we) dec_err = 1'b1;
`ifdef COUNTER_SNAPSHOT_EN
            else if (ins_snap_valid) begin
               dec_rdata   = ins_shadow;
               dec_ins_use = 1'b1;
            end
`endif
            else dec_rdata = instret_count[63:32];
         end
         A_INHIBIT: begin
            if (csr_we) dec_wr_inhibit = 1'b1;
            else        dec_rdata = {29'd0, instret_keep, 1'b0, cycle_keep};
         end
         A_CYC_CLR: dec_clr_cyc = csr_we;
         A_INS_CLR: dec_clr_ins = csr_we;
         default:   dec_err = 1'b1;
      endcase
   end

   // Response outputs are zero outside the ack cycle; an async reset drops
   // an in-flight ack or clear pulse immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_IDLE;
         csr_ack       <= 1'b0;
         csr_err       <= 1'b0;
         csr_rdata     <= '0;
         cycle_keep    <= 1'b0;
         instret_keep  <= 1'b0;
         cycle_clear   <= 1'b0;
         instret_clear <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignment so all flops
         // update together from pre-edge values, regardless of statement order.
         state         <= state_next;
         csr_ack       <= accept;
         csr_err       <= accept && dec_err;
         csr_rdata     <= accept ? dec_rdata : '0;
         cycle_clear   <= accept && dec_clr_cyc;
         instret_clear <= accept && dec_clr_ins;
         if (accept && dec_wr_inhibit) begin
            cycle_keep   <= csr_wdata[0];
            instret_keep <= csr_wdata[2];
         end
      end
   end

`ifdef COUNTER_SNAPSHOT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc_snap_valid <= 1'b0;
         ins_snap_valid <= 1'b0;
         // NOTE: only the valid flags matter functionally; the shadow data is
         // reset too so it never carries X into a read path.
         cyc_shadow     <= '0;
         ins_shadow     <= '0;
      end else if (accept) begin
         if (dec_cyc_load) begin
            cyc_shadow     <= cycle_count[63:32];
            cyc_snap_valid <= 1'b1;
         end else if (dec_cyc_use || dec_clr_cyc) begin
            cyc_snap_valid <= 1'b0;
         end
         if (dec_ins_load) begin
            ins_shadow     <= instret_count[63:32];
            ins_snap_valid <= 1'b1;
         end else if (dec_ins_use || dec_clr_ins) begin
            ins_snap_valid <= 1'b0;
         end
      end
   end
`endif

endmodule
